lenet_predict_mul_share_arb: RTL and testbench

Round-robin arbiter that time-shares one 3-bit × 6-bit unsigned multiplier (8-bit truncated product) among `NREQ` requesters inside `lenet_predict`. Each requester presents operands on a valid/ready channel. The block grants one requester per cycle, multiplies its operands, and registers the product into a single-entry output buffer. The buffer drains on one shared response channel that is tagged with the requester index. It sits between the convolution/pooling index-computation loops and the shared multiplier resource.

---
 rtl/lenet_predict_mul_share_arb.sv | 89 ++++++++
 tb/tb_lenet_predict_mul_share_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lenet_predict_mul_share_arb.sv
// Round-robin arbiter sharing one 3x6-bit unsigned multiplier among NREQ requesters.
// The product is registered into a single-entry buffer that drains on a tagged response channel.
module lenet_predict_mul_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_a,
   input  logic [6*NREQ-1:0] req_b,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [7:0]        resp_data,
   output logic [IDW-1:0]    resp_id,
   output logic [CNTW-1:0]   op_count,
   output logic              buf_full
);

   // Handshake: a transfer happens on a channel only in a cycle where both valid and ready
   // are high at the rising edge; ready never depends on the operand values.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

   buf_state_t       state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   grant;
   logic [IDW:0]     sum;
   logic             any_valid;
   logic             slot_free;
   logic             accept;
   logic [2:0]       a_sel;
   logic [5:0]       b_sel;
   logic [8:0]       prod;

   // Walk from the lowest priority offset down so the nearest valid index to ptr wins last.
   always_comb begin
      any_valid = 1'b0;
      grant     = ptr;
      sum       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDW + 1)'(k);
         if (sum >= (IDW + 1)'(NREQ)) sum = sum - (IDW + 1)'(NREQ);
         if (req_valid[sum[IDW-1:0]]) begin
            grant     = sum[IDW-1:0];
            any_valid = 1'b1;
         end
      end
   end

   assign slot_free = (state == EMPTY) | resp_ready;
   assign accept    = any_valid & slot_free & ap_rst_n;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   assign a_sel = req_a[3*grant +: 3];
   assign b_sel = req_b[6*grant +: 6];
   assign prod  = 9'(a_sel) * 9'(b_sel);

   assign resp_valid = (state == FULL);
   assign buf_full   = (state == FULL);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= EMPTY;
         resp_data <= '0;
         resp_id   <= '0;
         op_count  <= '0;
         ptr       <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) state <= FULL;
            FULL:  if (resp_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
         if (accept) begin
            resp_data <= prod[7:0];
            resp_id   <= grant;
            ptr       <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
            if (op_count != '1) op_count <= op_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lenet_predict_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter: reset, single op, truncation,
// round-robin order, backpressure, async reset mid-stream and op_count saturation.
module tb_lenet_predict_mul_share_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int CNTW = 4;

   logic              ap_clk;
   logic              ap_rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_a;
   logic [6*NREQ-1:0] req_b;
   logic              resp_valid;
   logic              resp_ready;
   logic [7:0]        resp_data;
   logic [IDW-1:0]    resp_id;
   logic [CNTW-1:0]   op_count;
   logic              buf_full;

   int vectors;
   int miscompares;

   // Operand table for the streaming phases; products hand-computed: 1*10, 2*17, 3*24, 7*63 mod 256.
   logic [2:0] tab_a [4];
   logic [5:0] tab_b [4];
   logic [7:0] tab_p [4];

   lenet_predict_mul_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .op_count   (op_count),
      .buf_full   (buf_full)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] a, input logic [5:0] b);
      req_a[3*i +: 3] = a;
      req_b[6*i +: 6] = b;
   endtask

   task automatic load_table();
      for (int i = 0; i < NREQ; i++) set_req(i, tab_a[i], tab_b[i]);
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                            input logic [IDW-1:0] id, input logic [CNTW-1:0] cnt);
      check({tag, "_valid"}, 32'(resp_valid), 32'(v));
      check({tag, "_data"},  32'(resp_data),  32'(d));
      check({tag, "_id"},    32'(resp_id),    32'(id));
      check({tag, "_count"}, 32'(op_count),   32'(cnt));
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      tab_a = '{3'd1, 3'd2, 3'd3, 3'd7};
      tab_b = '{6'd10, 6'd17, 6'd24, 6'd63};
      tab_p = '{8'd10, 8'd34, 8'd72, 8'd185};
      ap_rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      resp_ready = 1'b0;

      // Reset state, with every requester valid: ready must stay low.
      #1;
      req_valid = '1;
      resp_ready = 1'b1;
      #1;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_buf_full", 32'(buf_full), 32'h0);
      check_out("rst", 1'b0, 8'd0, 2'd0, 4'd0);

      // Single op from r1: 5*13 = 65, ready same cycle.
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      req_valid = 4'b0010;
      set_req(1, 3'd5, 6'd13);
      #1;
      check("single_ready", 32'(req_ready), 32'b0010);
      @(posedge ap_clk); #1;
      check_out("single", 1'b1, 8'd65, 2'd1, 4'd1);

      // Truncation: 7*63 = 441 -> 185 (ptr=2, r1 still wins). Then 0*63 on r2.
      @(negedge ap_clk);
      set_req(1, 3'd7, 6'd63);
      #1;
      check("trunc_ready", 32'(req_ready), 32'b0010);
      @(posedge ap_clk); #1;
      check_out("trunc", 1'b1, 8'd185, 2'd1, 4'd2);
      @(negedge ap_clk);
      req_valid = 4'b0100;
      set_req(2, 3'd0, 6'd63);
      @(posedge ap_clk); #1;
      check_out("zero", 1'b1, 8'd0, 2'd2, 4'd3);

      // Round robin with all valid; ptr is 3, so order 3,0,1,2,3,0,1,2.
      @(negedge ap_clk);
      load_table();
      req_valid = '1;
      for (int c = 0; c < 8; c++) begin
         if (c != 0) @(negedge ap_clk);
         #1;
         check($sformatf("rr%0d_ready", c), 32'(req_ready), 32'(1 << ((3 + c) % 4)));
         @(posedge ap_clk); #1;
         check($sformatf("rr%0d_id", c), 32'(resp_id), 32'((3 + c) % 4));
         check($sformatf("rr%0d_data", c), 32'(resp_data), 32'(tab_p[(3 + c) % 4]));
      end
      check("rr_count", 32'(op_count), 32'd11);

      // Backpressure: r2 produces 3*4=12 (ptr=3 -> search 3,0,1,2).
      @(negedge ap_clk);
      req_valid = 4'b0100;
      set_req(2, 3'd3, 6'd4);
      @(posedge ap_clk); #1;
      check_out("bp_load", 1'b1, 8'd12, 2'd2, 4'd12);
      @(negedge ap_clk);
      resp_ready = 1'b0;
      req_valid = 4'b1001;
      set_req(0, 3'd2, 6'd5);
      set_req(3, 3'd6, 6'd50);
      for (int c = 0; c < 5; c++) begin
         if (c != 0) @(negedge ap_clk);
         #1;
         check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
         @(posedge ap_clk); #1;
         check_out($sformatf("bp%0d", c), 1'b1, 8'd12, 2'd2, 4'd12);
      end
      // Release: drain + r3 accept on the same edge (6*50=300 -> 44), then r0 (2*5=10).
      @(negedge ap_clk);
      resp_ready = 1'b1;
      #1;
      check("rel_ready", 32'(req_ready), 32'b1000);
      @(posedge ap_clk); #1;
      check_out("rel_r3", 1'b1, 8'd44, 2'd3, 4'd13);
      @(negedge ap_clk);
      req_valid = 4'b0001;
      #1;
      check("rel_r0_ready", 32'(req_ready), 32'b0001);
      @(posedge ap_clk); #1;
      check_out("rel_r0", 1'b1, 8'd10, 2'd0, 4'd14);
      // Drain without accept: valid drops, data/id hold.
      @(negedge ap_clk);
      req_valid = '0;
      @(posedge ap_clk); #1;
      check_out("drain", 1'b0, 8'd10, 2'd0, 4'd14);

      // Load a pending result, then reset asynchronously between edges.
      @(negedge ap_clk);
      resp_ready = 1'b0;
      req_valid = 4'b0010;
      set_req(1, 3'd5, 6'd13);
      @(posedge ap_clk); #1;
      check_out("pre_rst", 1'b1, 8'd65, 2'd1, 4'd15);
      @(negedge ap_clk);
      req_valid = '0;
      #2;
      ap_rst_n = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 8'd0, 2'd0, 4'd0);
      @(posedge ap_clk); #1;
      check_out("rst_hold", 1'b0, 8'd0, 2'd0, 4'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      resp_ready = 1'b1;
      @(posedge ap_clk); #1;
      check("post_rst_no_resp", 32'(resp_valid), 32'h0);

      // Saturation: 20 ops from ptr=0, order 0,1,2,3,...; op_count stops at 15.
      @(negedge ap_clk);
      load_table();
      req_valid = '1;
      for (int c = 0; c < 20; c++) begin
         if (c != 0) @(negedge ap_clk);
         #1;
         check($sformatf("sat%0d_ready", c), 32'(req_ready), 32'(1 << (c % 4)));
         @(posedge ap_clk); #1;
         check_out($sformatf("sat%0d", c), 1'b1, tab_p[c % 4], 2'(c % 4),
                   4'((c + 1 > 15) ? 15 : c + 1));
      end
      @(negedge ap_clk);
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
